// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//
// Shared types and constants for the instruction-fetch stage.
//
//   fetch_state_e : fetch FSM state
//                   EMPTY  - nothing valid in flight
//                   STREAM - imem_rdata is the word for req_pc_q
//                   HELD   - the word for req_pc_q sits in the hold buffer
//   NOP_INSTR     : canonical RV32I NOP (addi x0, x0, 0). It is presented
//                   whenever the stage has nothing valid to offer.
//   PC_STEP       : byte distance between consecutive instruction words.
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      STREAM = 2'd1,
      HELD   = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int unsigned PC_STEP   = 4;

endpackage : fetch_pkg

// File: rtl/fetch_hold_buf.sv
// ---------------------------------------------------------------------------
// fetch_hold_buf
//
// One-entry capture register for an instruction word. The fetch FSM loads it
// when the word on the memory read port would otherwise be lost (a stall
// while streaming). It clears it when the held word is squashed (redirect).
//
// Ports
//   clk_i    in  1      clock
//   rst_i    in  1      synchronous, active-high reset
//   load_i   in  1      capture data_i on the next rising edge
//   clear_i  in  1      discard the held word (takes priority over load_i)
//   data_i   in  WIDTH  word to capture
//   data_o   out WIDTH  captured word
// ---------------------------------------------------------------------------
module fetch_hold_buf #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q;

   // NOTE: sequential state is assigned with <= only, so every flop samples
   // the values from before the edge no matter how the blocks are ordered.
   // NOTE: this storage is reset even though it is only read while the FSM
   // says it is valid. After reset or a squash it then holds a known value
   // and never an old instruction.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= data_i;
      end
   end

   assign data_o = data_q;

endmodule : fetch_hold_buf

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. It owns the PC, drives a synchronous-read
// instruction memory (one cycle of read latency) and pairs each returned word
// with the PC that requested it. The result {pc_f, pc_plus4_f, instr_f,
// valid_f} goes to the fetch/decode pipeline register.
//
// A one-entry hold buffer catches the word that is in flight when a stall
// arrives. While the stall lasts, the memory keeps re-reading the next
// address, so the word after the held one is already on imem_rdata when the
// stall releases. Stall release therefore costs no bubble.
//
// Priority: rst > redirect_f > stall_f.
//
// Parameters
//   WIDTH     data/address width
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk              in  1      clock
//   rst              in  1      synchronous, active-high reset
//   stall_f          in  1      hazard-unit stall; hold the current output
//   redirect_f       in  1      taken branch/jump resolved in execute
//   redirect_target  in  WIDTH  new PC; bits [1:0] are ignored (forced to 0)
//   imem_addr        out WIDTH  memory address, driven straight from pc_q
//   imem_rdata       in  WIDTH  word for the address presented last cycle
//   pc_f             out WIDTH  PC of instr_f (0 when not valid)
//   pc_plus4_f       out WIDTH  pc_f + 4 modulo 2^WIDTH (0 when not valid)
//   instr_f          out WIDTH  instruction to decode (NOP when not valid)
//   valid_f          out 1      instr_f is a real instruction
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   fetch_cnt        out 32     cycles that deliver an instruction downstream
//                               (valid_f & !stall_f & !redirect_f)
//   bubble_cnt       out 32     cycles with valid_f = 0
//   Both counters wrap and are cleared by rst.
// ---------------------------------------------------------------------------
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_f,
   input  logic             redirect_f,
   input  logic [WIDTH-1:0] redirect_target,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] pc_f,
   output logic [WIDTH-1:0] pc_plus4_f,
   output logic [WIDTH-1:0] instr_f,
   output logic             valid_f
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      fetch_cnt,
   output logic [31:0]      bubble_cnt
`endif
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);
   localparam logic [WIDTH-1:0] NOP  = WIDTH'(NOP_INSTR);

   fetch_state_e     state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] req_pc_q, req_pc_d;
   logic [WIDTH-1:0] hold_instr_q;
   logic             hold_load, hold_clear;

   // The two low target bits are dropped by design; this name records that.
   logic unused_target_lo;
   assign unused_target_lo = ^redirect_target[1:0];

   // ------------------------------------------------------------------
   // Hold buffer
   // ------------------------------------------------------------------
   fetch_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold_buf (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (hold_load),
      .clear_i (hold_clear),
      .data_i  (imem_rdata),
      .data_o  (hold_instr_q)
   );

   // ------------------------------------------------------------------
   // State and PC registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   // NOTE: every signal written here gets a default first. No path can
   // leave a signal unassigned, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      hold_load  = 1'b0;
      hold_clear = 1'b0;
      valid_f    = 1'b0;
      instr_f    = NOP;
      pc_f       = '0;
      pc_plus4_f = '0;

      if (redirect_f) begin
         // Squash everything in flight, whatever the stall says. Outputs keep
         // their EMPTY defaults for this cycle.
         pc_d       = {redirect_target[WIDTH-1:2], 2'b00};
         state_d    = EMPTY;
         hold_clear = 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (!stall_f) begin
                  state_d  = STREAM;
                  req_pc_d = pc_q;
                  pc_d     = pc_q + STEP;
               end
            end

            STREAM: begin
               valid_f    = 1'b1;
               instr_f    = imem_rdata;
               pc_f       = req_pc_q;
               pc_plus4_f = req_pc_q + STEP;
               if (stall_f) begin
                  // The read port moves on next cycle, so keep this word.
                  // pc_q stays put, and the memory keeps returning the
                  // following word for the whole stall.
                  state_d   = HELD;
                  hold_load = 1'b1;
               end else begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + STEP;
               end
            end

            HELD: begin
               valid_f    = 1'b1;
               instr_f    = hold_instr_q;
               pc_f       = req_pc_q;
               pc_plus4_f = req_pc_q + STEP;
               if (!stall_f) begin
                  // The memory has been re-reading pc_q, so the word for pc_q
                  // is on imem_rdata at the next edge. Tag it, then advance
                  // the request pointer the same way STREAM does. This keeps
                  // the word for pc_q from being fetched a second time.
                  state_d  = STREAM;
                  req_pc_d = pc_q;
                  pc_d     = pc_q + STEP;
               end
            end

            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   assign imem_addr = pc_q;

   // ------------------------------------------------------------------
   // Optional performance counters
   // ------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] bubble_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (valid_f && !stall_f && !redirect_f) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (!valid_f) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_cnt  = fetch_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. The stimulus drives reset, stall and
// redirect. A behavioural memory returns addr ^ 32'hA5A5_0000 one cycle
// after the address. Whenever the stimulus starts a new fetch stream (reset
// or redirect), it loads the expected program-order PCs into a queue.
// A monitor runs on the falling edge. It pops the queue each time an
// instruction is handed downstream, and it checks the timing rules at the
// interface level:
//   - after rst or a redirect, one empty cycle follows;
//   - once valid, the stage stays valid until a redirect or reset;
//   - while empty, the stage turns valid the cycle after stall is low;
//   - outputs do not change while stalled.
// With FETCH_PERF_CNT_EN defined, the counters are checked against counts
// the bench keeps itself.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam int          WIDTH    = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        stall_f;
   logic        redirect_f;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_f;
   logic [31:0] pc_plus4_f;
   logic [31:0] instr_f;
   logic        valid_f;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];

   fetch_stage #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_f         (stall_f),
      .redirect_f      (redirect_f),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .pc_f            (pc_f),
      .pc_plus4_f      (pc_plus4_f),
      .instr_f         (instr_f),
      .valid_f         (valid_f)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt       (fetch_cnt),
      .bubble_cnt      (bubble_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ MEM_KEY;
   endfunction

   // Synchronous-read instruction memory.
   always @(posedge clk) imem_rdata <= mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Program order from a new start address: start, start+4, ... (wrapping).
   task automatic restart_stream(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [31:0] tgt);
      redirect_f      = 1'b1;
      redirect_target = tgt;
      restart_stream({tgt[31:2], 2'b00});
      tick();
      redirect_f      = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      restart_stream(RESET_PC);
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   logic        nxt_valid = 1'b0;
   logic        exp_valid;
   logic        have_prev = 1'b0;
   logic        prev_stall;
   logic        prev_valid;
   logic [31:0] prev_pc, prev_p4, prev_instr;
   logic [31:0] m_fetch = '0;
   logic [31:0] m_bubble = '0;
   logic [31:0] e_pc;

   always @(negedge clk) begin
      if (rst) begin
         nxt_valid = 1'b0;
         have_prev = 1'b0;
         m_fetch   = '0;
         m_bubble  = '0;
      end else begin
         exp_valid = nxt_valid && !redirect_f;
         check("valid", {31'd0, valid_f}, {31'd0, exp_valid});

         if (exp_valid) begin
            check("pc_plus4", pc_plus4_f, pc_f + 32'd4);
            if (!stall_f) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL queue_underflow: got pc 0x%08h expected no delivery at %0t", pc_f, $time);
               end else begin
                  e_pc = exp_q.pop_front();
                  check("pc", pc_f, e_pc);
                  check("instr", instr_f, mem_word(e_pc));
               end
            end
         end else begin
            check("empty_pc", pc_f, 32'd0);
            check("empty_pc4", pc_plus4_f, 32'd0);
            check("empty_instr", instr_f, NOP_INSTR);
         end

         if (have_prev && prev_stall && !redirect_f) begin
            check("stall_hold_valid", {31'd0, valid_f}, {31'd0, prev_valid});
            check("stall_hold_pc", pc_f, prev_pc);
            check("stall_hold_pc4", pc_plus4_f, prev_p4);
            check("stall_hold_instr", instr_f, prev_instr);
         end

`ifdef FETCH_PERF_CNT_EN
         check("fetch_cnt", fetch_cnt, m_fetch);
         check("bubble_cnt", bubble_cnt, m_bubble);
`endif
         if (exp_valid && !stall_f) m_fetch = m_fetch + 32'd1;
         if (!exp_valid) m_bubble = m_bubble + 32'd1;

         nxt_valid  = !redirect_f && (exp_valid || !stall_f);
         have_prev  = 1'b1;
         prev_stall = stall_f;
         prev_valid = valid_f;
         prev_pc    = pc_f;
         prev_p4    = pc_plus4_f;
         prev_instr = instr_f;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int          since_redir;
      int          r;
      logic [31:0] tgt;

      rst             = 1'b1;
      stall_f         = 1'b0;
      redirect_f      = 1'b0;
      redirect_target = '0;
      restart_stream(RESET_PC);
      repeat (2) tick();
      rst = 1'b0;                    // cycle 1: bubble

      // Reset then stream: cycle 2 pc 0, cycle 3 pc 4, cycle 4 pc 8.
      tick();
      tick();
      tick();

      // Stall for 3 cycles while pc_f = 8.
      stall_f = 1'b1;
      repeat (3) tick();
      stall_f = 1'b0;                // release cycle, still pc 8
      tick();                        // pc 12
      tick();                        // pc 16

      // Redirect to 0x100 while pc_f = 16.
      do_redirect(32'h0000_0100);
      repeat (4) tick();

      // Redirect during HELD, with a misaligned target.
      do_redirect(32'h0000_0014);
      tick();                        // pc 0x14
      stall_f = 1'b1;
      tick();                        // HELD at 0x14
      do_redirect(32'h0000_0043);    // stall still high
      tick();
      stall_f = 1'b0;
      repeat (4) tick();

      // Reset in the middle of HELD, then stall in EMPTY for 4 cycles.
      stall_f = 1'b1;
      repeat (2) tick();
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("empty_stall_addr", imem_addr, RESET_PC);
         @(posedge clk);
         #1;
      end
      stall_f = 1'b0;
      repeat (4) tick();

      // PC wrap.
      do_redirect(32'hFFFF_FFFC);
      repeat (5) tick();

      // Random stalls, redirects and resets.
      since_redir = 0;
      for (int c = 0; c < 3000; c++) begin
         r       = int'($urandom_range(0, 999));
         stall_f = ($urandom_range(0, 99) < 30);
         if (r < 4) begin
            do_reset(1 + int'($urandom_range(0, 1)));
            since_redir = 0;
         end else if (r < 60 || since_redir > 200) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
            do_redirect(tgt);
            since_redir = 0;
         end else begin
            tick();
            since_redir++;
         end
      end

      stall_f = 1'b0;
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_fetch_stage
